// File: rtl/sdram_arbiter_rr.sv
// Request-driven arbiter for the single SDRAM controller port: fixed-priority client plus round-robin.
// Optional watchdog (sticky arb_error) is built in when ARB_TIMEOUT_EN is defined.
module sdram_arbiter_rr #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 128,
    parameter int BE_W        = DATA_W / 8,
    parameter int PRIO_CLIENT = 0,
    parameter int MAX_BURST   = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_CLIENTS-1:0]           req_rd,
    input  logic [NUM_CLIENTS-1:0]           req_wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]    req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0]    req_wrdata,
    input  logic [NUM_CLIENTS*BE_W-1:0]      req_be,
    output logic [NUM_CLIENTS-1:0]           client_ac,
    output logic [NUM_CLIENTS-1:0]           client_wait,
    output logic [DATA_W-1:0]                client_rddata,
    output logic                             grant_valid,
    output logic [$clog2(NUM_CLIENTS)-1:0]   grant_id,
    output logic [ADDR_W-1:0]                ar_addr,
    output logic [BE_W-1:0]                  ar_be,
    output logic                             ar_read,
    output logic                             ar_write,
    output logic [DATA_W-1:0]                ar_wrdata,
    input  logic [DATA_W-1:0]                ar_rddata,
    input  logic                             ar_ac,
    output logic                             arb_error
);

    localparam int ID_W = $clog2(NUM_CLIENTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;

    logic [NUM_CLIENTS-1:0] req_any;
    logic [NUM_CLIENTS-1:0] arb_req;
    logic [ID_W:0]          win;
    logic                   preempt;
    logic                   timeout_hit;

    logic [ADDR_W-1:0] addr_arr   [NUM_CLIENTS];
    logic [DATA_W-1:0] wrdata_arr [NUM_CLIENTS];
    logic [BE_W-1:0]   be_arr     [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign addr_arr[i]   = req_addr[i*ADDR_W +: ADDR_W];
        assign wrdata_arr[i] = req_wrdata[i*DATA_W +: DATA_W];
        assign be_arr[i]     = req_be[i*BE_W +: BE_W];
    end

    // Returns {found, index}: priority client first, else nearest requester after 'last'.
    function automatic logic [ID_W:0] arbitrate(input logic [NUM_CLIENTS-1:0] reqs,
                                                input logic [ID_W-1:0]        last);
        logic [ID_W:0] result;
        int            idx;
        result = '0;
        if (reqs[PRIO_CLIENT]) begin
            result = {1'b1, ID_W'(PRIO_CLIENT)};
        end else begin
            for (int k = NUM_CLIENTS; k >= 1; k--) begin
                idx = int'(last) + k;
                if (idx >= NUM_CLIENTS) idx -= NUM_CLIENTS;
                if (idx != PRIO_CLIENT && reqs[ID_W'(idx)]) result = {1'b1, ID_W'(idx)};
            end
        end
        return result;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               excl_q, excl_d;
    logic               arb_error_q, arb_error_d;

    assign timeout_hit = (timer_q == TIMER_W'(TIMEOUT_CYC - 1));
    assign arb_error   = arb_error_q;

    always_comb begin
        timer_d     = '0;
        excl_d      = 1'b0;
        arb_error_d = arb_error_q;
        if (state_q == S_ISSUE && !ar_ac) begin
            if (timeout_hit) begin
                excl_d      = 1'b1;
                arb_error_d = 1'b1;
            end else begin
                timer_d = timer_q + TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q     <= '0;
            excl_q      <= 1'b0;
            arb_error_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            excl_q      <= excl_d;
            arb_error_q <= arb_error_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign arb_error   = 1'b0;
`endif

    assign req_any       = req_rd | req_wr;
    assign client_rddata = ar_rddata;
    assign grant_valid   = grant_valid_q;
    assign grant_id      = grant_id_q;

    always_comb begin
        arb_req = req_any;
`ifdef ARB_TIMEOUT_EN
        // After a watchdog expiry the stalled client sits out exactly one decision.
        if (excl_q) arb_req[grant_id_q] = 1'b0;
`endif
    end

    assign win     = arbitrate(arb_req, last_grant_q);
    assign preempt = req_any[PRIO_CLIENT] && (grant_id_q != ID_W'(PRIO_CLIENT));

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        last_grant_d  = last_grant_q;
        burst_cnt_d   = burst_cnt_q;
        client_wait   = '1;
        client_ac     = '0;
        ar_read       = 1'b0;
        ar_write      = 1'b0;
        ar_addr       = '0;
        ar_be         = '1;
        ar_wrdata     = '0;

        case (state_q)
            S_IDLE: begin
                if (win[ID_W]) begin
                    grant_id_d    = win[ID_W-1:0];
                    grant_valid_d = 1'b1;
                    burst_cnt_d   = '0;
                    state_d       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                client_wait[grant_id_q] = 1'b0;
                ar_addr   = addr_arr[grant_id_q];
                ar_wrdata = wrdata_arr[grant_id_q];
                // A simultaneous read stays pending until the write has completed.
                if (req_wr[grant_id_q]) begin
                    ar_write = 1'b1;
                    ar_be    = be_arr[grant_id_q];
                end else begin
                    ar_read = req_rd[grant_id_q];
                end
                if (ar_ac) begin
                    client_ac[grant_id_q] = 1'b1;
                    burst_cnt_d  = burst_cnt_q + 8'd1;
                    last_grant_d = grant_id_q;
                    state_d      = S_RELEASE;
                end else if (timeout_hit) begin
                    last_grant_d = grant_id_q;
                    state_d      = S_RELEASE;
                end
            end

            S_RELEASE: begin
                client_wait[grant_id_q] = 1'b0;
`ifdef ARB_TIMEOUT_EN
                if (!excl_q && !preempt && req_any[grant_id_q] && burst_cnt_q < 8'(MAX_BURST)) begin
`else
                if (!preempt && req_any[grant_id_q] && burst_cnt_q < 8'(MAX_BURST)) begin
`endif
                    state_d = S_ISSUE;
                end else if (win[ID_W]) begin
                    grant_id_d  = win[ID_W-1:0];
                    burst_cnt_d = '0;
                    state_d     = S_ISSUE;
                end else begin
                    grant_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            last_grant_q  <= ID_W'(NUM_CLIENTS - 1);
            burst_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            last_grant_q  <= last_grant_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// Self-checking bench for sdram_arbiter_rr: vector table, scoreboard of expected completions,
// and hand-written sequences for round-robin bursts, preemption, write/read split, reset and watchdog.
module tb_sdram_arbiter_rr;

    localparam int NC     = 4;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 128;
    localparam int BE_W   = 16;

    typedef logic [127:0] w_t;

    logic                    clk;
    logic                    reset_n;
    logic [NC-1:0]           req_rd;
    logic [NC-1:0]           req_wr;
    logic [NC*ADDR_W-1:0]    req_addr;
    logic [NC*DATA_W-1:0]    req_wrdata;
    logic [NC*BE_W-1:0]      req_be;
    logic [NC-1:0]           client_ac;
    logic [NC-1:0]           client_wait;
    logic [DATA_W-1:0]       client_rddata;
    logic                    grant_valid;
    logic [1:0]              grant_id;
    logic [ADDR_W-1:0]       ar_addr;
    logic [BE_W-1:0]         ar_be;
    logic                    ar_read;
    logic                    ar_write;
    logic [DATA_W-1:0]       ar_wrdata;
    logic [DATA_W-1:0]       ar_rddata;
    logic                    ar_ac;
    logic                    arb_error;

    sdram_arbiter_rr #(
        .NUM_CLIENTS (NC),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BE_W        (BE_W),
        .PRIO_CLIENT (0),
        .MAX_BURST   (2),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wrdata    (req_wrdata),
        .req_be        (req_be),
        .client_ac     (client_ac),
        .client_wait   (client_wait),
        .client_rddata (client_rddata),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .ar_addr       (ar_addr),
        .ar_be         (ar_be),
        .ar_read       (ar_read),
        .ar_write      (ar_write),
        .ar_wrdata     (ar_wrdata),
        .ar_rddata     (ar_rddata),
        .ar_ac         (ar_ac),
        .arb_error     (arb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int               id;
        logic [DATA_W-1:0] rddata;
    } exp_t;

    typedef struct {
        int                c;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              exp_read;
        logic              exp_write;
        logic [BE_W-1:0]   exp_be;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input w_t act, input w_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_pat(input int n);
        return {4{32'hD00D_0000 + 32'(n)}};
    endfunction

    task automatic push_exp(input int id, input logic [DATA_W-1:0] d);
        exp_t e;
        e.id     = id;
        e.rddata = d;
        sb_q.push_back(e);
    endtask

    task automatic set_client(input int c, input logic [ADDR_W-1:0] a,
                              input logic [BE_W-1:0] b, input logic [DATA_W-1:0] d);
        req_addr[c*ADDR_W +: ADDR_W]   = a;
        req_be[c*BE_W +: BE_W]         = b;
        req_wrdata[c*DATA_W +: DATA_W] = d;
    endtask

    // Returns at negedge+1 of the first cycle with a strobe, or flags a timeout.
    task automatic wait_strobe(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!(ar_read || ar_write) && cyc < 40);
        if (!(ar_read || ar_write)) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no strobe within 40 cycles", name);
        end
    endtask

    // Controller acknowledge; compares the completion against the scoreboard head.
    task automatic ack(input logic [DATA_W-1:0] rdata);
        exp_t e;
        logic [NC-1:0] ac_exp;
        ar_rddata = rdata;
        ar_ac     = 1'b1;
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: ack with no expected completion");
        end else begin
            e = sb_q.pop_front();
            ac_exp = NC'(1) << e.id;
            check("ac_grant_id", w_t'(grant_id), w_t'(e.id));
            check("client_ac", w_t'(client_ac), w_t'(ac_exp));
            check("client_rddata", w_t'(client_rddata), w_t'(e.rddata));
        end
        @(posedge clk);
        #1;
        ar_ac = 1'b0;
    endtask

    task automatic expect_idle(input string name);
        @(negedge clk);
        @(negedge clk);
        #1;
        check(name, w_t'({grant_valid, client_wait, ar_read, ar_write}), w_t'(7'b0_1111_00));
    endtask

    vec_t vecs[6];
    int   order[6];

    initial begin
        logic [NC-1:0] wexp;
        int            cnt;

        vecs[0] = '{0, 1'b1, 1'b0, 22'h3FFFFF, 16'h0000, {4{32'h0101_0101}}, 1'b1, 1'b0, 16'hFFFF};
        vecs[1] = '{1, 1'b0, 1'b1, 22'h000001, 16'h0001, {4{32'hA5A5_5A5A}}, 1'b0, 1'b1, 16'h0001};
        vecs[2] = '{2, 1'b0, 1'b1, 22'h2AAAAA, 16'hFFFF, {4{32'h1234_5678}}, 1'b0, 1'b1, 16'hFFFF};
        vecs[3] = '{3, 1'b1, 1'b0, 22'h155555, 16'h0F0F, {4{32'hCAFE_F00D}}, 1'b1, 1'b0, 16'hFFFF};
        vecs[4] = '{1, 1'b1, 1'b0, 22'h000000, 16'h00FF, {4{32'h0BAD_BEEF}}, 1'b1, 1'b0, 16'hFFFF};
        vecs[5] = '{0, 1'b0, 1'b1, 22'h000100, 16'h8000, {4{32'hFEED_FACE}}, 1'b0, 1'b1, 16'h8000};
        order   = '{1, 1, 3, 3, 1, 1};

        reset_n    = 1'b0;
        req_rd     = '0;
        req_wr     = '0;
        req_addr   = '1;
        req_wrdata = '1;
        req_be     = '1;
        ar_rddata  = '0;
        ar_ac      = 1'b1;

        // Reset state, with a stray ar_ac that must not leak through.
        #2;
        check("rst_grant_valid", w_t'(grant_valid), w_t'(0));
        check("rst_grant_id", w_t'(grant_id), w_t'(0));
        check("rst_client_wait", w_t'(client_wait), w_t'(4'hF));
        check("rst_client_ac", w_t'(client_ac), w_t'(0));
        check("rst_strobes", w_t'({ar_read, ar_write}), w_t'(0));
        check("rst_ar_addr", w_t'(ar_addr), w_t'(0));
        check("rst_ar_be", w_t'(ar_be), w_t'(16'hFFFF));
        check("rst_ar_wrdata", w_t'(ar_wrdata), w_t'(0));
        check("rst_arb_error", w_t'(arb_error), w_t'(0));

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("idle_ac_ignored", w_t'(client_ac), w_t'(0));
        @(negedge clk);
        ar_ac = 1'b0;
        #1;
        check("idle_after_ac", w_t'(grant_valid), w_t'(0));

        // Single read from client 2: strobe at t+1, ack at t+3, RELEASE at t+4.
        @(negedge clk);
        set_client(2, 22'h00123, '1, {4{32'h2222_2222}});
        req_rd[2] = 1'b1;
        push_exp(2, rd_pat(0));
        @(negedge clk);
        #1;
        check("t1_ar_read", w_t'({ar_read, ar_write}), w_t'(2'b10));
        check("t1_ar_addr", w_t'(ar_addr), w_t'(22'h00123));
        check("t1_client_wait", w_t'(client_wait), w_t'(4'b1011));
        check("t1_grant", w_t'({grant_valid, grant_id}), w_t'(3'b1_10));
        @(negedge clk);
        #1;
        check("t2_ar_read_held", w_t'(ar_read), w_t'(1));
        @(negedge clk);
        #1;
        ack(rd_pat(0));
        req_rd[2] = 1'b0;
        @(negedge clk);
        #1;
        check("t4_release_strobes", w_t'({ar_read, ar_write}), w_t'(0));
        check("t4_release_wait", w_t'(client_wait), w_t'(4'b1011));
        check("t4_release_valid", w_t'(grant_valid), w_t'(1));
        @(negedge clk);
        #1;
        check("t5_idle", w_t'({grant_valid, client_wait}), w_t'(5'b0_1111));

        // Table of single transactions, each separated by an idle cycle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_client(vecs[i].c, vecs[i].addr, vecs[i].be, vecs[i].wdata);
            req_rd[vecs[i].c] = vecs[i].rd;
            req_wr[vecs[i].c] = vecs[i].wr;
            push_exp(vecs[i].c, rd_pat(i + 1));
            wait_strobe("vec_strobe");
            wexp = ~(NC'(1) << vecs[i].c);
            check("vec_ar_read", w_t'(ar_read), w_t'(vecs[i].exp_read));
            check("vec_ar_write", w_t'(ar_write), w_t'(vecs[i].exp_write));
            check("vec_ar_be", w_t'(ar_be), w_t'(vecs[i].exp_be));
            check("vec_ar_addr", w_t'(ar_addr), w_t'(vecs[i].addr));
            check("vec_ar_wrdata", w_t'(ar_wrdata), w_t'(vecs[i].wdata));
            check("vec_client_wait", w_t'(client_wait), w_t'(wexp));
            ack(rd_pat(i + 1));
            req_rd = '0;
            req_wr = '0;
            expect_idle("vec_idle");
        end

        // Clients 1 and 3 held continuously: bursts of two, alternating.
        @(negedge clk);
        req_rd[1] = 1'b1;
        req_rd[3] = 1'b1;
        for (int k = 0; k < 6; k++) push_exp(order[k], rd_pat(10 + k));
        for (int k = 0; k < 6; k++) begin
            wait_strobe("rr_strobe");
            check("rr_order", w_t'(grant_id), w_t'(order[k]));
            ack(rd_pat(10 + k));
        end
        req_rd = '0;
        expect_idle("rr_idle");

        // Priority client arrives mid-access: current access finishes, then client 0 wins.
        @(negedge clk);
        set_client(0, 22'h0ABCDE, '1, {4{32'h0000_0C00}});
        req_rd[1] = 1'b1;
        push_exp(1, rd_pat(20));
        push_exp(1, rd_pat(21));
        push_exp(0, rd_pat(22));
        wait_strobe("pre_strobe0");
        ack(rd_pat(20));
        wait_strobe("pre_strobe1");
        check("pre_burst_same", w_t'(grant_id), w_t'(1));
        req_rd[0] = 1'b1;
        @(negedge clk);
        #1;
        check("pre_no_midaccess", w_t'({grant_id, ar_read}), w_t'(3'b01_1));
        ack(rd_pat(21));
        wait_strobe("pre_strobe2");
        check("pre_prio_grant", w_t'(grant_id), w_t'(0));
        check("pre_prio_addr", w_t'(ar_addr), w_t'(22'h0ABCDE));
        check("pre_prio_wait", w_t'(client_wait), w_t'(4'b1110));
        ack(rd_pat(22));
        req_rd = '0;
        expect_idle("pre_idle");

        // Read and write together: the write goes first, the read follows.
        @(negedge clk);
        set_client(3, 22'h0155AA, 16'h00F0, {4{32'h3333_CCCC}});
        req_wr[3] = 1'b1;
        req_rd[3] = 1'b1;
        push_exp(3, rd_pat(30));
        push_exp(3, rd_pat(31));
        wait_strobe("rw_strobe0");
        check("rw_write_first", w_t'({ar_read, ar_write}), w_t'(2'b01));
        check("rw_write_be", w_t'(ar_be), w_t'(16'h00F0));
        check("rw_write_data", w_t'(ar_wrdata), w_t'({4{32'h3333_CCCC}}));
        check("rw_write_wait", w_t'(client_wait), w_t'(4'b0111));
        ack(rd_pat(30));
        req_wr[3] = 1'b0;
        wait_strobe("rw_strobe1");
        check("rw_read_next", w_t'({ar_read, ar_write}), w_t'(2'b10));
        check("rw_read_be", w_t'(ar_be), w_t'(16'hFFFF));
        check("rw_read_grant", w_t'(grant_id), w_t'(3));
        ack(rd_pat(31));
        req_rd = '0;
        expect_idle("rw_idle");

        // Reset mid-write: strobes drop at once and no completion is reported.
        @(negedge clk);
        set_client(2, 22'h001234, 16'h0F00, {4{32'h7777_7777}});
        req_wr[2] = 1'b1;
        wait_strobe("mr_strobe");
        @(negedge clk);
        reset_n = 1'b0;
        ar_ac   = 1'b1;
        #1;
        check("mr_write_dropped", w_t'({ar_read, ar_write}), w_t'(0));
        check("mr_no_ac", w_t'(client_ac), w_t'(0));
        check("mr_outputs", w_t'({grant_valid, client_wait, ar_addr, ar_be}),
              w_t'({1'b0, 4'hF, 22'h0, 16'hFFFF}));
        @(negedge clk);
        ar_ac  = 1'b0;
        req_wr = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("mr_idle_after", w_t'({grant_valid, ar_read, ar_write}), w_t'(0));

`ifdef ARB_TIMEOUT_EN
        // Controller never acknowledges client 2; after 15 ISSUE cycles client 1 takes over.
        @(negedge clk);
        set_client(2, 22'h002222, '1, {4{32'h2020_2020}});
        set_client(1, 22'h001111, '1, {4{32'h1010_1010}});
        req_rd[2] = 1'b1;
        push_exp(1, rd_pat(40));
        wait_strobe("to_strobe0");
        check("to_first_grant", w_t'(grant_id), w_t'(2));
        req_rd[1] = 1'b1;
        cnt = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (!ar_read) break;
            cnt++;
        end
        check("to_issue_cycles", w_t'(cnt), w_t'(15));
        check("to_arb_error", w_t'(arb_error), w_t'(1));
        check("to_no_ac", w_t'(client_ac), w_t'(0));
        wait_strobe("to_strobe1");
        check("to_next_grant", w_t'(grant_id), w_t'(1));
        check("to_next_addr", w_t'(ar_addr), w_t'(22'h001111));
        ack(rd_pat(40));
        req_rd = '0;
        expect_idle("to_idle");
        check("to_error_sticky", w_t'(arb_error), w_t'(1));
`else
        check("no_timeout_error", w_t'(arb_error), w_t'(0));
`endif

        check("sb_drained", w_t'(sb_q.size()), w_t'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter_rr.md
Name: sdram_arbiter_rr

Overview:
- Parametrised N-client arbiter in front of the single SDRAM controller port (ar_*).
- Replaces the hard-coded, frame-phase-sequenced client selection with request-driven arbitration: one fixed high-priority client (line buffer) plus round-robin among the rest.
- Adds a burst cap so no client can monopolise the port.
- Each client keeps the existing rd/wr + ac + wait handshake unchanged.

Parameters:
NUM_CLIENTS, 4, number of clients (2..8)
ADDR_W, 22, SDRAM word address width
DATA_W, 128, data width per access
BE_W, DATA_W/8, byte-enable width
PRIO_CLIENT, 0, index of the fixed-priority client
MAX_BURST, 8, max back-to-back grants to one client before forced re-arbitration (1..255)
TIMEOUT_CYC, 1023, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_rd  in  NUM_CLIENTS  per-client read request, held until client_ac
req_wr  in  NUM_CLIENTS  per-client write request, held until client_ac
req_addr  in  NUM_CLIENTS*ADDR_W  packed per-client address, client i at [i*ADDR_W +: ADDR_W]
req_wrdata  in  NUM_CLIENTS*DATA_W  packed per-client write data
req_be  in  NUM_CLIENTS*BE_W  packed per-client byte enables
client_ac  out  NUM_CLIENTS  one-cycle completion pulse to the granted client
client_wait  out  NUM_CLIENTS  0 = client owns the port; 1 = client must wait
client_rddata  out  DATA_W  broadcast read data; equals ar_rddata
grant_valid  out  1  a client currently holds the port
grant_id  out  $clog2(NUM_CLIENTS)  index of the granted client
ar_addr  out  ADDR_W  controller address
ar_be  out  BE_W  controller byte enables
ar_read  out  1  controller read strobe
ar_write  out  1  controller write strobe
ar_wrdata  out  DATA_W  controller write data
ar_rddata  in  DATA_W  controller read data
ar_ac  in  1  controller acknowledge, one-cycle pulse
arb_error  out  1  sticky watchdog error flag (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset, asynchronous while reset_n=0:
  - state=IDLE, grant_valid=0, grant_id=0, client_wait all 1, client_ac all 0.
  - ar_read=0, ar_write=0, ar_addr=0, ar_be all 1, ar_wrdata=0.
  - last_grant=NUM_CLIENTS-1, burst_cnt=0, arb_error=0.
  - Reset mid-access drops strobes immediately and discards the transaction; no ac is issued.
- A client requests when req_rd[i] or req_wr[i] is 1.
- Arbitration rule, applied in IDLE and RELEASE:
  - If PRIO_CLIENT requests, it wins.
  - Otherwise the first requester found searching upward from last_grant+1, modulo NUM_CLIENTS, skipping PRIO_CLIENT, wins.
- IDLE:
  - No strobes asserted.
  - If any client requests, register the winner into grant_id, set grant_valid=1, burst_cnt=0, and go to ISSUE.
  - Latency: request seen in cycle t gives a strobe in cycle t+1.
- ISSUE:
  - client_wait[grant_id]=0; all other client_wait=1.
  - ar_addr and ar_wrdata are muxed from the granted client's slice.
  - If req_wr: ar_write=1, ar_be=req_be slice. Else ar_read=req_rd, ar_be=all 1.
  - If rd and wr are both set, the write is issued; the read stays pending for a later grant.
  - On ar_ac=1: client_ac[grant_id]=1 combinationally in the same cycle, burst_cnt+1, last_grant=grant_id, then go to RELEASE.
  - If the granted client drops its request before ac, strobes drop; the grant stays until ac or the watchdog fires.
- RELEASE (one cycle):
  - No strobes; client_wait[grant_id] stays 0 so the client can present its next request.
  - If PRIO_CLIENT requests and is not the current grantee, it wins (preemption happens only at this boundary).
  - Else if the current client requests and burst_cnt<MAX_BURST, go back to ISSUE with the same grant_id (burst_cnt kept).
  - Else re-arbitrate; on a new winner set burst_cnt=0 and go to ISSUE. If no requests, set grant_valid=0 and go to IDLE.
- ar_ac seen in IDLE or RELEASE is ignored.
- client_rddata=ar_rddata at all times; it is valid only in the cycle client_ac is high.
- Sustained throughput: one access per 2 cycles plus controller latency.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A counter runs in ISSUE and clears on entry to ISSUE.
  - If it reaches TIMEOUT_CYC without ar_ac: drop strobes, set arb_error=1 (sticky until reset), give no client_ac, set last_grant=grant_id, go to RELEASE, and force re-arbitration excluding the current client for that decision.
- Undefined: no counter; arb_error is tied to 0; ISSUE waits for ar_ac indefinitely.

Test Plan:
- Reset release, then req_rd[2]=1 at t, addr 0x00123 → ar_read=1 at t+1 with ar_addr=0x00123, client_wait=4'b1011; ar_ac at t+3 → client_ac[2] pulse at t+3, RELEASE at t+4.
- req_rd[1] and req_rd[3] held continuously, MAX_BURST=2 → grant order 1,1,3,3,1,1 (bursts of 2 alternating), each with client_ac.
- Client 1 bursting; req_rd[0] rises mid-access → client 1 access completes, then client 0 is granted at the next RELEASE with burst_cnt=0.
- Client 3 with req_wr=1, req_rd=1, req_be=16'h00F0 → ar_write=1, ar_read=0, ar_be=16'h00F0; after ac the read is granted next with ar_be=16'hFFFF.
- reset_n pulled low 1 cycle after ar_write is asserted → ar_write=0 immediately, no client_ac, IDLE and grant_valid=0 after release.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=15, ar_ac never asserted → strobes drop after 15 ISSUE cycles, arb_error=1, and another requesting client is granted.
